// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control sequencer:
//   state_t        - sequencer state and its 3-bit encoding (exported on the state port)
//   STG_*          - bit index of each stage within stage_go / stage_done
//   END_OPCODE     - opcode that ends the program
//   stage_onehot() - stage_go pattern owned by a stage state
//   is_stage()     - true for the five busy states FETCH..WB
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam logic [5:0] END_OPCODE = 6'b111111;

    function automatic logic [4:0] stage_onehot(input state_t s);
        case (s)
            ST_FETCH:  return 5'b00001 << STG_IF;
            ST_DECODE: return 5'b00001 << STG_ID;
            ST_EXEC:   return 5'b00001 << STG_EX;
            ST_MEM:    return 5'b00001 << STG_MEM;
            ST_WB:     return 5'b00001 << STG_WB;
            default:   return 5'b00000;
        endcase
    endfunction

    function automatic logic is_stage(input state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
               (s == ST_MEM)   || (s == ST_WB);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog
// Per-stage timeout counter for stage_sequencer.
//   clk, rst   - clock, synchronous active-high reset
//   clear_i    - stage go issued this cycle; restarts the count
//   wait_i     - stage is waiting for its done this cycle
//   expired_o  - TIMEOUT cycles will have elapsed since the go at the next edge
// TIMEOUT = 0 disables expiry.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic wait_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // cnt_q holds the number of cycles elapsed since the go cycle
    logic [CW-1:0] cnt_q, cnt_d, elapsed;

    always_comb begin
        elapsed = clear_i ? '0 : cnt_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = CW'(1);
        end else if (wait_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Expires during the cycle that ends the TIMEOUT-th cycle after the go
        expired_o = (TIMEOUT != 0) && (clear_i || wait_i) &&
                    ((32'(elapsed) + 32'd1) >= TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer
// Multicycle MIPS control sequencer: owns the stage token, issues one-cycle
// go pulses to IF/ID/EX/MEM/WB in turn and waits for each stage's done.
//   clk, rst                  - clock, synchronous active-high reset
//   start                     - begin execution from IDLE or HALT
//   stage_done[4:0]           - per-stage completion pulses (IF..WB)
//   end_program, mem_access,
//   reg_write                 - decode results, sampled on decode done
//   branch_taken              - execute result, sampled on execute done
//   stage_go[4:0]             - one-hot, one-cycle stage start pulse
//   pc_sel                    - branch-target select, coincident with fetch go
//   busy / halted / error     - FETCH..WB / HALT / ERROR
//   state[2:0]                - current state encoding
//   cycle_count, instr_count  - saturating busy-cycle and retire counters
// Build option: MEM_SKIP_EN - route around MEM/WB using the latched decode flags.
module stage_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       stage_done,
    input  logic             end_program,
    input  logic             mem_access,
    input  logic             reg_write,
    input  logic             branch_taken,
    output logic [4:0]       stage_go,
    output logic             pc_sel,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t             state_q, state_d, nxt;
    logic               entry_q, entry_d;   // stage state entered, go still owed
    logic [4:0]         go_q, go_d;
    logic               pc_q, pc_d;
    logic               mem_q, mem_d;
    logic               rw_q, rw_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ins_q, ins_d;

    logic               in_stage, waiting, done_ok, wd_expired, retire;

    assign in_stage = is_stage(state_q);
    // Done is only honoured after the go cycle, and only for the current stage
    assign waiting  = in_stage && !entry_q && (go_q == '0);
    assign done_ok  = waiting && |(stage_done & stage_onehot(state_q));

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (|go_q),
        .wait_i    (waiting),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        go_d    = '0;
        pc_d    = 1'b0;
        mem_d   = mem_q;
        rw_d    = rw_q;
        br_d    = br_q;
        nxt     = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    entry_d = 1'b1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                if (entry_q) begin
                    go_d = stage_onehot(state_q);
                    if (state_q == ST_FETCH) begin
                        pc_d = br_q;
                        br_d = 1'b0;
                    end
                end else if (done_ok) begin
                    case (state_q)
                        ST_FETCH: nxt = ST_DECODE;
                        ST_DECODE: begin
                            mem_d = mem_access;
                            rw_d  = reg_write;
                            nxt   = end_program ? ST_HALT : ST_EXEC;
                        end
                        ST_EXEC: begin
                            br_d = branch_taken;
`ifdef MEM_SKIP_EN
                            nxt = mem_q ? ST_MEM : (rw_q ? ST_WB : ST_FETCH);
`else
                            nxt = ST_MEM;
`endif
                        end
                        ST_MEM: begin
`ifdef MEM_SKIP_EN
                            nxt = rw_q ? ST_WB : ST_FETCH;
`else
                            nxt = ST_WB;
`endif
                        end
                        default: nxt = ST_FETCH;
                    endcase
                    state_d = nxt;
                    entry_d = (nxt != ST_HALT);
                    retire  = (nxt == ST_FETCH);
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                end
            end
        endcase

        cyc_d = (in_stage && (cyc_q != '1)) ? cyc_q + CNT_W'(1) : cyc_q;
        ins_d = (retire && (ins_q != '1)) ? ins_q + CNT_W'(1) : ins_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            entry_q <= 1'b0;
            go_q    <= '0;
            pc_q    <= 1'b0;
            mem_q   <= 1'b0;
            rw_q    <= 1'b0;
            br_q    <= 1'b0;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            go_q    <= go_d;
            pc_q    <= pc_d;
            mem_q   <= mem_d;
            rw_q    <= rw_d;
            br_q    <= br_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
        end
    end

    // Decode flags only steer routing when MEM_SKIP_EN is set
    logic unused_sink;
`ifdef MEM_SKIP_EN
    assign unused_sink = ^END_OPCODE;
`else
    assign unused_sink = ^{END_OPCODE, mem_q, rw_q};
`endif

    assign stage_go    = go_q;
    assign pc_sel      = pc_q;
    assign busy        = in_stage;
    assign halted      = (state_q == ST_HALT);
    assign error       = (state_q == ST_ERROR);
    assign state       = state_q;
    assign cycle_count = cyc_q;
    assign instr_count = ins_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer
// Builds a cycle-indexed timeline from instruction-level rules (stage list per
// instruction, go = entry+1, done = go+delay, next entry = done+1), drives the
// planned inputs and compares every DUT output against the timeline each cycle.
// Honours MEM_SKIP_EN the same way the design does.
module tb_stage_sequencer;
    import mips_ctrl_pkg::*;

    localparam int N = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, end_program, mem_access, reg_write, branch_taken;
    logic [4:0]  stage_done, stage_go;
    logic        pc_sel, busy, halted, error;
    logic [2:0]  state;
    logic [31:0] cycle_count, instr_count;

    stage_sequencer #(.TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .stage_done(stage_done),
        .end_program(end_program), .mem_access(mem_access), .reg_write(reg_write),
        .branch_taken(branch_taken), .stage_go(stage_go), .pc_sel(pc_sel),
        .busy(busy), .halted(halted), .error(error), .state(state),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    // planned inputs per cycle
    logic [4:0]  d_done [N];
    logic        d_start[N], d_rst[N], d_endp[N], d_mem[N], d_rw[N], d_br[N];
    // expected outputs per cycle
    state_t      e_state[N];
    logic [4:0]  e_go   [N];
    logic        e_pc   [N], e_icinc[N];
    logic [31:0] e_cc   [N], e_ic[N];

    int total = 0;
    int bad   = 0;
    int last;
    int lit_go, lit_a, lit_h, lit_err, lit_rst;

    function automatic state_t st_of(input int idx);
        case (idx)
            STG_IF:  return ST_FETCH;
            STG_ID:  return ST_DECODE;
            STG_EX:  return ST_EXEC;
            STG_MEM: return ST_MEM;
            default: return ST_WB;
        endcase
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
               (s == ST_MEM) || (s == ST_WB);
    endfunction

    task automatic check(input string nm, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    task automatic fill_state(input int a, input int b, input state_t s);
        for (int c = a; c <= b; c++) e_state[c] = s;
    endtask

    // One stage visit entered at e; returns e = entry cycle of the next state.
    // nz adds a same-cycle done (ignored) and foreign done bits (ignored).
    task automatic stage(inout int e, input int idx, input int d, input logic pc,
                         input logic nz);
        int go;
        go = e + 1;
        e_go[go][idx] = 1'b1;
        e_pc[go] = pc;
        fill_state(e, go + d, st_of(idx));
        d_done[go + d][idx] = 1'b1;
        if (nz) begin
            d_done[go][idx] = 1'b1;
            d_done[go + 1] = d_done[go + 1] | ~(5'b00001 << idx);
        end
        e = go + d + 1;
    endtask

    task automatic instr(inout int e, inout logic pcp, input logic mem, input logic rw,
                         input logic br, input logic endp, input int d, input logic nz,
                         output logic hlt);
        int dn;
        hlt = 1'b0;
        stage(e, STG_IF, d, pcp, nz);
        pcp = 1'b0;
        dn = e + 1 + d;
        d_endp[dn] = endp; d_mem[dn] = mem; d_rw[dn] = rw;
        stage(e, STG_ID, d, 1'b0, nz);
        if (endp) begin
            hlt = 1'b1;
            return;
        end
        d_br[e + 1 + d] = br;
        stage(e, STG_EX, d, 1'b0, nz);
`ifdef MEM_SKIP_EN
        if (mem) stage(e, STG_MEM, d, 1'b0, nz);
        if (rw)  stage(e, STG_WB, d, 1'b0, nz);
`else
        stage(e, STG_MEM, d, 1'b0, nz);
        stage(e, STG_WB, d, 1'b0, nz);
`endif
        e_icinc[e] = 1'b1;
        pcp = br;
    endtask

    task automatic drive(input int c);
        rst = d_rst[c]; start = d_start[c]; stage_done = d_done[c];
        end_program = d_endp[c]; mem_access = d_mem[c];
        reg_write = d_rw[c]; branch_taken = d_br[c];
    endtask

    initial begin
        int   e, g;
        logic pcp, hlt;
        for (int c = 0; c < N; c++) begin
            d_done[c] = '0; d_start[c] = 0; d_rst[c] = 0; d_endp[c] = 0;
            d_mem[c] = 0; d_rw[c] = 0; d_br[c] = 0;
            e_state[c] = ST_IDLE; e_go[c] = '0; e_pc[c] = 0; e_icinc[c] = 0;
        end

        // reset, then start from IDLE
        d_rst[0] = 1; d_rst[1] = 1; d_rst[2] = 1;
        d_start[4] = 1; e = 5; pcp = 0; lit_go = 6;
        instr(e, pcp, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, hlt);   // R-type
        lit_a = e;
        instr(e, pcp, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, hlt);   // lw
        instr(e, pcp, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, hlt);   // beq taken
        instr(e, pcp, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, hlt);   // sw, fetch with pc_sel
        instr(e, pcp, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, hlt);   // end of program
        lit_h = e;
        fill_state(e, e + 3, ST_HALT);
        d_start[e + 3] = 1; d_done[e + 3] = 5'h1f;              // start wins in HALT
        e = e + 4;
        d_start[e + 3] = 1;                                      // start while busy
        instr(e, pcp, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, hlt);   // noisy done lines
        instr(e, pcp, 1'b0, 1'b1, 1'b0, 1'b0, 7, 1'b0, hlt);   // done on expiry cycle

        // execute done withheld -> ERROR, start ignored, then rst
        stage(e, STG_IF, 2, pcp, 1'b0);
        d_rw[e + 3] = 1;
        stage(e, STG_ID, 2, 1'b0, 1'b0);
        g = e + 1; lit_err = g;
        e_go[g][STG_EX] = 1'b1;
        fill_state(e, g + 7, ST_EXEC);
        fill_state(g + 8, g + 20, ST_ERROR);
        d_start[g + 12] = 1;
        d_rst[g + 20] = 1;
        d_start[g + 23] = 1; e = g + 24; pcp = 0;

        // reset in MEM with done still pending; late done afterwards
        stage(e, STG_IF, 2, 1'b0, 1'b0);
        d_mem[e + 3] = 1; d_rw[e + 3] = 1;
        stage(e, STG_ID, 2, 1'b0, 1'b0);
        stage(e, STG_EX, 2, 1'b0, 1'b0);
        g = e + 1;
        e_go[g][STG_MEM] = 1'b1;
        fill_state(e, g + 1, ST_MEM);
        d_rst[g + 1] = 1;
        d_done[g + 2][STG_MEM] = 1'b1; d_done[g + 3][STG_MEM] = 1'b1;
        lit_rst = g + 2;
        last = g + 8;

        // counters from the state timeline
        e_cc[0] = 0; e_ic[0] = 0;
        for (int c = 1; c < N; c++) begin
            if (d_rst[c - 1]) begin
                e_cc[c] = 0; e_ic[c] = 0;
            end else begin
                e_cc[c] = e_cc[c - 1] + (is_busy(e_state[c - 1]) ? 32'd1 : 32'd0);
                e_ic[c] = e_ic[c - 1] + (e_icinc[c] ? 32'd1 : 32'd0);
            end
        end

        drive(0);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            check("state",   c, 32'(state),    32'(e_state[c]));
            check("go",      c, 32'(stage_go), 32'(e_go[c]));
            check("pc_sel",  c, 32'(pc_sel),   32'(e_pc[c]));
            check("busy",    c, 32'(busy),     32'(is_busy(e_state[c])));
            check("halted",  c, 32'(halted),   32'(e_state[c] == ST_HALT));
            check("error",   c, 32'(error),    32'(e_state[c] == ST_ERROR));
            check("cyc_cnt", c, cycle_count,   e_cc[c]);
            check("ins_cnt", c, instr_count,   e_ic[c]);
            // hand-computed anchors
            if (c == lit_go) check("lit_first_if_go", c, 32'(stage_go), 32'h01);
            if (c == lit_a) begin
`ifdef MEM_SKIP_EN
                check("lit_a_cycle", c, 32'(lit_a), 32'd21);
                check("lit_a_cyc_cnt", c, cycle_count, 32'd16);
`else
                check("lit_a_cycle", c, 32'(lit_a), 32'd25);
                check("lit_a_cyc_cnt", c, cycle_count, 32'd20);
`endif
                check("lit_a_state", c, 32'(state), 32'(ST_FETCH));
                check("lit_a_ins_cnt", c, instr_count, 32'd1);
            end
            if (c == lit_h) begin
                check("lit_halt_halted", c, 32'(halted), 32'd1);
                check("lit_halt_ins_cnt", c, instr_count, 32'd4);
            end
            if (c == lit_err + 7) check("lit_err_before", c, 32'(error), 32'd0);
            if (c == lit_err + 8) check("lit_err_at", c, 32'(error), 32'd1);
            if (c == lit_rst) begin
                check("lit_rst_state", c, 32'(state), 32'(ST_IDLE));
                check("lit_rst_go", c, 32'(stage_go), 32'd0);
                check("lit_rst_cyc_cnt", c, cycle_count, 32'd0);
            end
            drive(c);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multicycle control sequencer for the MIPS datapath. It issues one-cycle go pulses to the fetch, decode, execute, memory and writeback stages in order, and waits for each stage's done pulse before moving on. It uses decode/execute results to pick the next stage, and stops on the end-of-program opcode. It replaces the ad-hoc stage-flag passing between stage modules with one owner of the stage token, and adds a per-stage watchdog and retire/cycle counters.

## Interface
- TIMEOUT, default 64: maximum cycles to wait for a stage's done after its go; 0 disables the watchdog.
- CNT_W, default 32: width of the cycle and instruction counters.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin execution from IDLE or HALT
- stage_done  in  5  per-stage completion pulse; bit 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback
- end_program  in  1  decode result (opcode 6'b111111); sampled on the decode done cycle
- mem_access  in  1  memRead|memWrite from decode; sampled on the decode done cycle
- reg_write  in  1  regWrite from decode; sampled on the decode done cycle
- branch_taken  in  1  execute result; sampled on the execute done cycle
- stage_go  out  5  one-hot, one-cycle start pulse per stage (same bit order)
- pc_sel  out  1  one-cycle pulse, coincident with the fetch go, selecting the branch target
- busy  out  1  high in FETCH..WB
- halted  out  1  high in HALT
- error  out  1  high in ERROR
- state  out  3  current state encoding
- cycle_count  out  CNT_W  cycles spent busy; saturating
- instr_count  out  CNT_W  retired instructions; saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- IDLE: start moves to FETCH.
- On entry to each stage state, the matching stage_go bit pulses for exactly one cycle in the following cycle. The state then waits for the matching stage_done bit.
  - Done bits for other stages are ignored.
  - A done asserted in the same cycle as its own go is ignored.
- Transitions:
  - FETCH done -> DECODE.
  - DECODE done -> HALT if end_program, else EXEC. mem_access and reg_write are latched on this cycle.
  - EXEC done -> MEM. branch_taken is latched on this cycle.
  - MEM done -> WB.
  - WB done -> FETCH; instr_count increments.
- Branch: if the latched branch_taken is 1, pc_sel pulses together with the next fetch go. The latch clears after use.
- HALT:
  - Entered from DECODE; the halting instruction is not counted.
  - start restarts at FETCH; counters are retained.
- ERROR: only rst exits.
- start while busy is ignored. start in ERROR is ignored.
- cycle_count increments every cycle busy=1. Both counters saturate at all-ones.
- Watchdog (sub-module):
  - Its counter clears on every go and increments while waiting.
  - When it reaches TIMEOUT before done arrives, the state becomes ERROR.
  - No go is issued in the transition cycle.

## Timing
- Reset: state=IDLE; stage_go=0; pc_sel=0; busy=0; halted=0; error=0; both counters=0; all latches=0. Reset mid-operation aborts immediately, with no further go.
- Latency from start to fetch go: 2 cycles (start sampled, then state FETCH, then go).
- Stage-to-stage overhead: done in cycle n -> next state in n+1 -> next go in n+2.
- Done and start in the same cycle in HALT: start wins only if no stage is pending (always true in HALT).
- With TIMEOUT=T, ERROR is entered T cycles after the go, provided done is still absent.
- Done arriving in the same cycle the watchdog expires: done wins.

## Configuration
- MEM_SKIP_EN defined:
  - EXEC done goes to MEM only if the latched mem_access=1. Otherwise it goes to WB if reg_write=1, else to FETCH.
  - MEM done goes to WB if reg_write=1, else to FETCH.
  - instr_count increments on whichever transition returns to FETCH.
- MEM_SKIP_EN undefined: every non-halting instruction visits all five stages.

## Structure
- Package mips_ctrl_pkg:
  - state enum and its 3-bit encoding.
  - stage index constants STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4.
  - END_OPCODE=6'b111111.
- Sub-module seq_watchdog: parameter TIMEOUT; inputs clear and wait; output expired.

## Test plan
1. Reset, start, R-type (mem_access=0, reg_write=1), each done 2 cycles after go, MEM_SKIP_EN on -> go order IF, ID, EX, WB; instr_count=1; cycle_count=16 at return to FETCH.
2. lw (mem_access=1, reg_write=1), MEM_SKIP_EN on -> go order IF, ID, EX, MEM, WB; then next IF go; instr_count=1.
3. beq taken (mem_access=0, reg_write=0, branch_taken=1), MEM_SKIP_EN on -> after EX done, next cycles give FETCH then IF go together with pc_sel=1 for one cycle; no WB go; instr_count=1. Repeat with the macro off -> MEM and WB visited.
4. end_program=1 at decode done -> HALT; halted=1; no EX go; instr_count unchanged; cycle_count frozen. start -> IF go 2 cycles later; halted=0.
5. TIMEOUT=8, execute done withheld -> error=1 exactly 8 cycles after the EX go; start ignored. rst -> IDLE, all outputs 0.
6. rst asserted mid-MEM with done pending -> next cycle IDLE; stage_go=0; counters=0. A late done is ignored.
